// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Load/store front end between the multi-cycle CPU controller and a
// byte-banked, big-endian 32-bit data memory. One request at a time is
// accepted. Byte, halfword and word loads are extracted from the memory
// word and sign- or zero-extended. Byte and halfword stores are done as
// read-modify-write. Misaligned requests are rejected without touching
// memory. Completion is signalled by a one-cycle done pulse.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req             request strobe, sampled only while busy = 0
//   we              1 = store, 0 = load
//   size            00 byte, 01 half, 10/11 word
//   uns             1 = zero-extend loads, 0 = sign-extend
//   addr            byte address
//   wdata           store data (low 8/16 bits for byte/half stores)
//   rdata           load result, held until the next load completes
//   done            one-cycle completion pulse
//   misalign        with done: the request was rejected
//   busy            request in progress (RD or WR)
//   mem_addr        word-aligned memory address
//   mem_wdata       memory write word
//   mem_read        memory read enable
//   mem_write       memory write enable, one cycle per store
//   mem_rdata       memory read word, byte offset 0 in bits [31:24]

module mem_access_unit #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          misalign,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wword_q, wword_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_align;

  // Halves must be 2-byte aligned, words (and size 11) 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if (sz == 2'b01)  r = off[0];
    else if (sz[1])   r = |off;
    return r;
  endfunction

  // Pick the addressed lane out of a big-endian word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = u ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = u ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overwrite the addressed lane of a word with store data; other bytes kept.
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign bad_align = is_misaligned(size, addr[1:0]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request directly so back-to-back costs no cycle.
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          off_d   = addr[1:0];
          maddr_d = {addr[AW-1:2], 2'b00};
          wdata_d = wdata;
          cnt_d   = ONE_C;
          mis_d   = bad_align;
          if (bad_align) begin
            state_d = S_DONE;
          end else if (we && size[1]) begin
            wword_d = wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else begin
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // mem_rdata is only trusted in the last cycle of the read window.
        if (cnt_q == LAT_C) begin
          if (we_q) begin
            wword_d = merge_lane(mem_rdata, wdata_q, size_q, off_q);
            state_d = S_WR;
          end else begin
            rdata_d = extract_lane(mem_rdata, size_q, off_q, uns_q);
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      maddr_q <= '0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops them in the same instant it forces IDLE.
  assign mem_read  = (state_q == S_RD);
  assign mem_write = (state_q == S_WR);
  assign busy      = (state_q == S_RD) || (state_q == S_WR);
  assign done      = (state_q == S_DONE);
  assign misalign  = (state_q == S_DONE) && mis_q;
  assign rdata     = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wword_q;

endmodule
